// File: rtl/waveform_analyzer.sv
// waveform_analyzer: measures the period of an asynchronous square wave in
// clk cycles and classifies it into a frequency band.
// wave_in is synchronized, rising edges are detected, and a counter measures
// the time between consecutive rises. A timeout flags loss of signal.
// Optional feature: define WAVE_AVG_EN to report the average of the last four
// periods instead of the raw single period.
module waveform_analyzer #(
    parameter int SYNC_STAGES = 2,
    parameter int HIGH_MAX    = 16,
    parameter int LOW_MIN     = 64,
    parameter int TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        wave_in,
    output logic [15:0] period_out,
    output logic [1:0]  freq_label,
    output logic        meas_valid,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [1:0] LABEL_LOW  = 2'b00;
    localparam logic [1:0] LABEL_MID  = 2'b01;
    localparam logic [1:0] LABEL_HIGH = 2'b10;
    localparam logic [1:0] LABEL_NONE = 2'b11;

    // Band classification of a period value.
    function automatic logic [1:0] band_of(input logic [15:0] p);
        if (p <= 16'(HIGH_MAX)) begin
            return LABEL_HIGH;
        end else if (p >= 16'(LOW_MIN)) begin
            return LABEL_LOW;
        end else begin
            return LABEL_MID;
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   wave_d_q, wave_d_d;
    logic                   wave_s;
    logic                   rise;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] period_q, period_d;
    logic [1:0]  label_q, label_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;

    logic        meas_evt;
    logic        tmo_evt;
    logic [15:0] meas_period;
    logic        meas_ok;

    assign wave_s = sync_q[SYNC_STAGES-1];
    assign rise   = wave_s & ~wave_d_q;

    // Synchronizer shift and one-cycle delay for edge detection.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], wave_in};
        wave_d_d = wave_s;
    end

    // Synchronizer and edge-detect registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            wave_d_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            wave_d_q <= wave_d_d;
        end
    end

    // Measurement and timeout events; a rise always beats the timeout.
    always_comb begin
        meas_evt = enable && (state_q == MEASURE) && rise;
        tmo_evt  = enable && (state_q != IDLE) && !rise && (cnt_q == 16'(TIMEOUT));
    end

`ifdef WAVE_AVG_EN
    // Four-entry period history with a running sum; the reported period is
    // the truncated mean once the history is full.
    logic [15:0] hist_q [4];
    logic [15:0] hist_d [4];
    logic [17:0] sum_q, sum_d;
    logic [2:0]  fill_q, fill_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [17:0] sum_new;
    logic        clr_hist;

    assign clr_hist = !enable || tmo_evt;
    // Oldest entry is replaced, so its value leaves the sum as the new one enters.
    assign sum_new  = sum_q + {2'b00, cnt_q} - {2'b00, hist_q[ptr_q]};

    // Averaged result offered to the main FSM for the current measurement.
    always_comb begin
        meas_period = sum_new[17:2];
        meas_ok     = (fill_q >= 3'd3);
    end

    // History bookkeeping: clear on loss of signal or disable, append on measure.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hist_d[i] = hist_q[i];
        end
        sum_d  = sum_q;
        fill_d = fill_q;
        ptr_d  = ptr_q;
        if (clr_hist) begin
            for (int i = 0; i < 4; i++) begin
                hist_d[i] = '0;
            end
            sum_d  = '0;
            fill_d = '0;
            ptr_d  = '0;
        end else if (meas_evt) begin
            hist_d[ptr_q] = cnt_q;
            sum_d         = sum_new;
            ptr_d         = ptr_q + 2'd1;
            fill_d        = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
        end
    end

    // History entry registers.
    for (genvar gi = 0; gi < 4; gi++) begin : g_hist
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                hist_q[gi] <= '0;
            end else begin
                hist_q[gi] <= hist_d[gi];
            end
        end
    end

    // Running sum, fill level and write pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q  <= '0;
            fill_q <= '0;
            ptr_q  <= '0;
        end else begin
            sum_q  <= sum_d;
            fill_q <= fill_d;
            ptr_q  <= ptr_d;
        end
    end
`else
    // Raw mode: every measurement is reported directly.
    always_comb begin
        meas_period = cnt_q;
        meas_ok     = 1'b1;
    end
`endif

    // FSM next state, period counter and output updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        label_d   = label_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM, MEASURE: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = 16'd1;
                    end else if (tmo_evt) begin
                        state_d   = ARM;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        label_d   = LABEL_NONE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (meas_evt) begin
                timeout_d = 1'b0;
                if (meas_ok) begin
                    period_d = meas_period;
                    label_d  = band_of(meas_period);
                    valid_d  = 1'b1;
                end
            end
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            label_q   <= LABEL_NONE;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            label_q   <= label_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_out = period_q;
    assign freq_label = label_q;
    assign meas_valid = valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Self-checking bench for waveform_analyzer (default parameters).
// Expected measurements are queued when each period is driven and checked
// when meas_valid fires. Defining WAVE_AVG_EN switches the expectation model
// to four-period averaging.
module tb_waveform_analyzer;

    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        wave_in;
    logic [15:0] period_out;
    logic [1:0]  freq_label;
    logic        meas_valid;
    logic        timeout;

    typedef struct {
        logic [15:0] p;
        logic [1:0]  l;
    } exp_t;

    exp_t        sb[$];
    int          hist[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_valid_cyc = -1;
    logic        prev_valid = 1'b0;
    logic [15:0] hold_p = 16'd0;
    logic [1:0]  hold_l = 2'b11;

    waveform_analyzer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wave_in    (wave_in),
        .period_out (period_out),
        .freq_label (freq_label),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_band(input int p);
        if (p <= 16) return 2'b10;
        if (p >= 64) return 2'b00;
        return 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue the expected report for a period that has just started.
    task automatic push_meas(input int p);
`ifdef WAVE_AVG_EN
        int s;
        hist.push_back(p);
        if (hist.size() > 4) hist.delete(0);
        if (hist.size() == 4) begin
            s = hist[0] + hist[1] + hist[2] + hist[3];
            sb.push_back('{p: 16'(s / 4), l: exp_band(s / 4)});
        end
`else
        sb.push_back('{p: 16'(p), l: exp_band(p)});
`endif
    endtask

    // One clock: sample outputs 1 time unit after the edge and score valids.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (meas_valid) begin
            chk("valid_consecutive", prev_valid, 0);
            if (sb.size() == 0) begin
                chk("unexpected_valid", meas_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("period_out", period_out, e.p);
                chk("freq_label", freq_label, e.l);
                $display("meas: period_out=%0d freq_label=%0b", period_out, freq_label);
                hold_p = e.p;
                hold_l = e.l;
                last_valid_cyc = cyc;
            end
        end
        prev_valid = meas_valid;
    endtask

    task automatic wave_period(input int p, input bit do_push);
        if (do_push) push_meas(p);
        wave_in = 1'b1;
        repeat (p / 2) tick();
        wave_in = 1'b0;
        repeat (p - p / 2) tick();
    endtask

    task automatic drain();
        repeat (4) tick();
        chk("missing_valid", sb.size(), 0);
    endtask

    initial begin
        int t_seen;
        reset   = 1'b1;
        enable  = 1'b0;
        wave_in = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_period", period_out, 0);
        chk("rst_label", freq_label, 2'b11);
        chk("rst_valid", meas_valid, 0);
        chk("rst_timeout", timeout, 0);
        repeat (3) tick();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (2) tick();

        // Fast wave, period 10: first report after the second rise.
        for (int i = 0; i < 6; i++) wave_period(10, i < 5);
        drain();

        // Asynchronous reset in the middle of a period.
        wave_in = 1'b1;
        repeat (2) tick();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midrst_period", period_out, 0);
        chk("midrst_label", freq_label, 2'b11);
        chk("midrst_valid", meas_valid, 0);
        chk("midrst_timeout", timeout, 0);
        hold_p = 16'd0;
        hold_l = 2'b11;
        hist.delete();
        sb.delete();
        wave_in = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();

        // Band edges.
        wave_period(16, 1);
        wave_period(17, 1);
        wave_period(63, 1);
        wave_period(64, 1);
        wave_period(64, 0);
        drain();
        chk("band_hold_period", period_out, hold_p);

        // Loss of signal: wave held low.
        t_seen = -1;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (timeout && t_seen < 0) begin
                t_seen = cyc;
                chk("timeout_cycle", t_seen - last_valid_cyc, TMO);
                chk("timeout_label", freq_label, 2'b11);
                chk("timeout_period_hold", period_out, hold_p);
            end
        end
        chk("timeout_sticky", timeout, 1);
        hold_l = 2'b11;
        hist.delete();
        wave_period(20, 1);
        wave_period(20, 0);
        drain();
        chk("timeout_cleared", timeout, 0);

        // Enable drop mid-period: outputs hold, no reports.
        enable = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) wave_period(12, 0);
        chk("dis_period_hold", period_out, hold_p);
        chk("dis_label_hold", freq_label, hold_l);
        chk("dis_valid", meas_valid, 0);
        hist.delete();
        enable = 1'b1;
        repeat (2) tick();
        wave_period(40, 1);
        wave_period(40, 0);
        drain();
        chk("reen_period", period_out, hold_p);

        // Mixed periods (averaged to 10 when averaging is enabled).
        enable = 1'b0;
        tick();
        hist.delete();
        enable = 1'b1;
        repeat (2) tick();
        wave_period(8, 1);
        wave_period(8, 1);
        wave_period(12, 1);
        wave_period(12, 1);
        wave_period(12, 0);
        drain();
        chk("mix_period", period_out, hold_p);
        chk("mix_label", freq_label, hold_l);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
